// File: rtl/aes_stream_adapter.sv
// 32-bit word-stream packer/unpacker around the iterative AES core.
// Optional stored-key reuse across blocks when AES_KEY_REUSE_EN is defined.
module aes_stream_adapter #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_mode,
  input  logic         s_newkey,
  output logic         aes_start,
  output logic         aes_mode,
  output logic [127:0] aes_key,
  output logic [127:0] aes_in,
  input  logic [127:0] aes_cipher,
  input  logic         aes_ready,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic         err_timeout
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    LOAD_KEY,
    LOAD_DATA,
    START,
    WAIT,
    DRAIN
  } state_t;

  state_t              state;
  logic [1:0]          cnt;
  logic [TCNT_W-1:0]   tcnt;
  logic [BLK_W-1:0]    out_q;
  logic                key_loaded;
  logic                s_fire;
  logic                m_fire;
  logic                reuse_c;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

`ifdef AES_KEY_REUSE_EN
  // First word of a block skips the key phase when a key is already stored.
  assign reuse_c = key_loaded && !s_newkey;
`else
  logic unused_ok;
  assign reuse_c   = 1'b0;
  assign unused_ok = ^{s_newkey, key_loaded};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD_KEY;
      cnt         <= '0;
      tcnt        <= '0;
      key_loaded  <= 1'b0;
      s_ready     <= 1'b1;
      aes_start   <= 1'b0;
      aes_mode    <= 1'b0;
      aes_key     <= '0;
      aes_in      <= '0;
      out_q       <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      aes_start   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        LOAD_KEY: begin
          if (s_fire) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd0) aes_mode <= s_mode;
            if (cnt == 2'd0 && reuse_c) begin
              aes_in <= {aes_in[BLK_W-WORD_W-1:0], s_data};
              state  <= LOAD_DATA;
            end else begin
              aes_key <= {aes_key[BLK_W-WORD_W-1:0], s_data};
              if (cnt == 2'd0) key_loaded <= 1'b0;
              if (cnt == 2'd3) begin
                key_loaded <= 1'b1;
                state      <= LOAD_DATA;
              end
            end
          end
        end
        LOAD_DATA: begin
          if (s_fire) begin
            cnt    <= cnt + 2'd1;
            aes_in <= {aes_in[BLK_W-WORD_W-1:0], s_data};
            if (cnt == 2'd3) begin
              s_ready   <= 1'b0;
              aes_start <= 1'b1;
              state     <= START;
            end
          end
        end
        START: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Key/data/mode stay frozen here; the core reads the key late.
          if (aes_ready) begin
            out_q   <= {aes_cipher[BLK_W-WORD_W-1:0], WORD_W'(0)};
            m_data  <= aes_cipher[BLK_W-1 -: WORD_W];
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            cnt     <= '0;
            state   <= DRAIN;
          end else if (tcnt == TCNT_W'(TIMEOUT)) begin
            err_timeout <= 1'b1;
            s_ready     <= 1'b1;
            cnt         <= '0;
            state       <= LOAD_KEY;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        DRAIN: begin
          if (m_fire) begin
            if (cnt == 2'd3) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              s_ready <= 1'b1;
              cnt     <= '0;
              state   <= LOAD_KEY;
            end else begin
              m_data <= out_q[BLK_W-1 -: WORD_W];
              out_q  <= {out_q[BLK_W-WORD_W-1:0], WORD_W'(0)};
              m_last <= (cnt == 2'd2);
              cnt    <= cnt + 2'd1;
            end
          end
        end
        default: begin
          s_ready <= 1'b1;
          cnt     <= '0;
          state   <= LOAD_KEY;
        end
      endcase
    end
  end

endmodule
